// File: rtl/seq_pkg.sv
// Shared constants for the X/Y/Z datapath sequencer: register commands, ULA select,
// opcodes and state encodings.
package seq_pkg;

  localparam logic [3:0] CLEAR  = 4'd0;
  localparam logic [3:0] LOAD   = 4'd1;
  localparam logic [3:0] HOLD   = 4'd2;
  localparam logic [3:0] SHIFTR = 4'd3;

  localparam logic [3:0] ULA_ADD = 4'd0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_AVG  = 2'd1,
    OP_CLR  = 2'd2,
    OP_HALF = 2'd3
  } op_e;

  // Encoding 7 is unused and recovers to ST_IDLE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADX  = 3'd1,
    ST_ACC    = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_STORE  = 3'd4,
    ST_CLRALL = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/seq_controle_if.sv
// Instruction handshake plus register-command bus between a requester and seq_controle.
interface seq_controle_if #(
  parameter int REP_W = 2
);

  logic             instr_valid;
  logic [1:0]       instr_op;
  logic [REP_W-1:0] instr_rep;
  logic             instr_ready;
  logic [3:0]       tx;
  logic [3:0]       ty;
  logic [3:0]       tz;
  logic [3:0]       tula;
  logic [3:0]       Q;
  logic             done;

  modport master (
    output instr_valid, instr_op, instr_rep,
    input  instr_ready, tx, ty, tz, tula, Q, done
  );

  modport slave (
    input  instr_valid, instr_op, instr_rep,
    output instr_ready, tx, ty, tz, tula, Q, done
  );

endinterface

// File: rtl/seq_rep_counter.sv
// ACC repeat counter: loads the repeat field, counts down to zero and holds there.
module seq_rep_counter #(
  parameter int REP_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [REP_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [REP_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - REP_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_controle.sv
// Instruction sequencer driving X/Y/Z register commands with Moore-decoded outputs.
// Optional macro SEQ_CONTROLE_STALL_EN adds a stall input that freezes the sequence.
module seq_controle
  import seq_pkg::*;
#(
  parameter int REP_W = 2
) (
  input logic clock,
  input logic reset,
`ifdef SEQ_CONTROLE_STALL_EN
  input logic stall,
`endif
  seq_controle_if.slave bus
);

  state_e     state;
  state_e     state_nxt;
  op_e        op_q;
  logic       frz;
  logic       ready;
  logic       accept;
  logic       cnt_zero;
  logic [3:0] tx;
  logic [3:0] ty;
  logic [3:0] tz;
  logic       dn;

`ifdef SEQ_CONTROLE_STALL_EN
  assign frz = stall;
`else
  assign frz = 1'b0;
`endif

  assign ready  = (state == ST_IDLE) && !frz;
  assign accept = bus.instr_valid && ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (!frz) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= OP_ADD;
    end else if (accept) begin
      op_q <= op_e'(bus.instr_op);
    end
  end

  seq_rep_counter #(
    .REP_W (REP_W)
  ) u_rep (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.instr_rep),
    .dec      ((state == ST_ACC) && !frz),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(bus.instr_op))
            OP_ADD, OP_AVG: state_nxt = ST_LOADX;
            OP_CLR:         state_nxt = ST_CLRALL;
            default:        state_nxt = ST_SHIFT;
          endcase
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOADX:  state_nxt = ST_ACC;
      // Counter at zero means this is the last accumulate cycle
      ST_ACC: begin
        if (!cnt_zero)             state_nxt = ST_ACC;
        else if (op_q == OP_AVG)   state_nxt = ST_SHIFT;
        else                       state_nxt = ST_STORE;
      end
      ST_SHIFT:  state_nxt = ST_STORE;
      ST_STORE:  state_nxt = ST_DONE;
      ST_CLRALL: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx = HOLD;
    ty = HOLD;
    tz = HOLD;
    dn = 1'b0;
    case (state)
      ST_LOADX:  tx = LOAD;
      ST_ACC:    ty = LOAD;
      ST_SHIFT:  ty = SHIFTR;
      ST_STORE:  tz = LOAD;
      ST_CLRALL: begin
        tx = CLEAR;
        ty = CLEAR;
        tz = CLEAR;
      end
      ST_DONE:   dn = 1'b1;
      default:   dn = 1'b0;
    endcase
    // A frozen sequence must not disturb the datapath
    if (frz) begin
      tx = HOLD;
      ty = HOLD;
      tz = HOLD;
      dn = 1'b0;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.tx          = tx;
  assign bus.ty          = ty;
  assign bus.tz          = tz;
  assign bus.tula        = ULA_ADD;
  assign bus.Q           = {1'b0, state};
  assign bus.done        = dn;

endmodule

// File: tb/tb_seq_controle.sv
// Bench for seq_controle: per-cycle command trace queue plus a done scoreboard
// checked against a small X/Y/Z datapath model.
module tb_seq_controle;
  import seq_pkg::*;

  localparam int REP_W = 2;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] tz;
    logic [3:0] tula;
    logic       done;
    logic       ready;
  } obs_t;

  typedef struct packed {
    logic [3:0] z;
    int         lat;
    int         acc_cyc;
  } res_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic [3:0] din   = 4'd0;
  logic [3:0] xr = 4'd0, yr = 4'd0, zr = 4'd0;
  logic [3:0] xa = 4'd0, ya = 4'd0, za = 4'd0;
  logic       resync = 1'b0;
  int         cyc = 0;
  int         stall_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_acc = 0;
  int         n_done = 0;
  obs_t       tq[$];
  res_t       dq[$];

  seq_controle_if #(.REP_W(REP_W)) bus();

  seq_controle #(
    .REP_W (REP_W)
  ) dut (
    .clock (clock),
    .reset (reset),
`ifdef SEQ_CONTROLE_STALL_EN
    .stall (stall),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Datapath the commands act on
  always @(posedge clock) begin
    case (bus.tx)
      CLEAR:   xr <= 4'd0;
      LOAD:    xr <= din;
      SHIFTR:  xr <= xr >> 1;
      default: xr <= xr;
    endcase
    case (bus.ty)
      CLEAR:   yr <= 4'd0;
      LOAD:    yr <= yr + xr;
      SHIFTR:  yr <= yr >> 1;
      default: yr <= yr;
    endcase
    case (bus.tz)
      CLEAR:   zr <= 4'd0;
      LOAD:    zr <= yr;
      default: zr <= zr;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic obs_t mk(input logic [3:0] q, input logic [3:0] tx, input logic [3:0] ty,
                              input logic [3:0] tz, input logic done, input logic ready);
    obs_t o;
    o.q = q; o.tx = tx; o.ty = ty; o.tz = tz; o.tula = 4'd0; o.done = done; o.ready = ready;
    return o;
  endfunction

  task automatic push_instr(input logic [1:0] op, input logic [REP_W-1:0] rep);
    res_t r;
    int   lat;
    case (op)
      2'd0, 2'd1: begin
        tq.push_back(mk(4'd1, 4'd1, 4'd2, 4'd2, 1'b0, 1'b0));
        for (int i = 0; i <= int'(rep); i++) begin
          tq.push_back(mk(4'd2, 4'd2, 4'd1, 4'd2, 1'b0, 1'b0));
          ya = ya + din;
        end
        xa  = din;
        lat = int'(rep) + 4;
        if (op == 2'd1) begin
          tq.push_back(mk(4'd3, 4'd2, 4'd3, 4'd2, 1'b0, 1'b0));
          ya  = ya >> 1;
          lat = lat + 1;
        end
        tq.push_back(mk(4'd4, 4'd2, 4'd2, 4'd1, 1'b0, 1'b0));
        za = ya;
      end
      2'd2: begin
        tq.push_back(mk(4'd5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        xa = 4'd0; ya = 4'd0; za = 4'd0;
        lat = 2;
      end
      default: begin
        tq.push_back(mk(4'd3, 4'd2, 4'd3, 4'd2, 1'b0, 1'b0));
        tq.push_back(mk(4'd4, 4'd2, 4'd2, 4'd1, 1'b0, 1'b0));
        ya  = ya >> 1;
        za  = ya;
        lat = 3;
      end
    endcase
    tq.push_back(mk(4'd6, 4'd2, 4'd2, 4'd2, 1'b1, 1'b0));
    r.z = za; r.lat = lat; r.acc_cyc = cyc;
    dq.push_back(r);
    stall_cnt = 0;
    n_acc++;
  endtask

  // Cycle monitor, sampled on the inactive edge
  always @(negedge clock) begin
    obs_t act, exp;
    res_t r;
    logic was_idle;
    act = mk(bus.Q, bus.tx, bus.ty, bus.tz, bus.done, bus.instr_ready);
    act.tula = bus.tula;
    was_idle = (tq.size() == 0);
    if (resync && !reset) begin
      xa = xr; ya = yr; za = zr;
      resync = 1'b0;
    end
    if (stall) begin
      exp = was_idle ? mk(4'd0, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0)
                     : mk(tq[0].q, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0);
      if (dq.size() != 0) stall_cnt++;
    end else if (was_idle) begin
      exp = mk(4'd0, 4'd2, 4'd2, 4'd2, 1'b0, 1'b1);
    end else begin
      exp = tq.pop_front();
    end
    chk("cycle", 32'(act), 32'(exp));
    if (bus.done === 1'b1) begin
      n_done++;
      if (dq.size() == 0) begin
        chk("unexpected_done", 32'(1), 32'(0));
      end else begin
        r = dq.pop_front();
        chk("z_value", 32'(zr), 32'(r.z));
        chk("latency", 32'(cyc - r.acc_cyc), 32'(r.lat + stall_cnt));
      end
    end
    if (reset) begin
      tq.delete();
      dq.delete();
      resync = 1'b1;
    end else if (!stall && was_idle && bus.instr_valid) begin
      push_instr(bus.instr_op, bus.instr_rep);
    end
  end

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic present(input logic [1:0] op, input logic [REP_W-1:0] rep, input logic [3:0] d);
    logic got = 1'b0;
    @(posedge clock); #1;
    din = d; bus.instr_op = op; bus.instr_rep = rep; bus.instr_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (bus.instr_ready === 1'b1 && !stall) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'(0), 32'(1));
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [REP_W-1:0] rep, input logic [3:0] d);
    present(op, rep, d);
    bus.instr_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = 2'd0;
    bus.instr_rep   = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    send(2'd0, 2'd0, 4'd5);
    chk("add_y", 32'(yr), 32'(5));
    send(2'd2, 2'd0, 4'd0);
    send(2'd1, 2'd2, 4'd6);
    send(2'd2, 2'd0, 4'd0);
    send(2'd0, 2'd0, 4'd8);
    send(2'd3, 2'd0, 4'd0);
    send(2'd0, 2'd3, 4'd1);

    // Abort an ADD rep=3 in its first ACC cycle
    present(2'd0, 2'd3, 4'd2);
    bus.instr_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) @(posedge clock);
    send(2'd2, 2'd0, 4'd0);

    // Valid held high, op changing after each accept
    for (int i = 0; i < 20; i++) begin
      present(2'(i % 4), 2'((i * 3) % 4), 4'(i + 1));
    end
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 40 && tq.size() != 0; i++) @(negedge clock);
    chk("drain", 32'(tq.size()), 32'(0));

`ifdef SEQ_CONTROLE_STALL_EN
    send(2'd2, 2'd0, 4'd0);
    present(2'd1, 2'd1, 4'd3);
    bus.instr_valid = 1'b0;
    @(posedge clock); #1;
    stall = 1'b1;
    repeat (3) @(posedge clock);
    #1 stall = 1'b0;
    wait_done();
`endif

    repeat (3) @(posedge clock);
    chk("done_count", 32'(n_done), 32'(n_acc - 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
